// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RV32I load/store definitions: funct3 encodings for
//               memory accesses, the load/store unit state encoding, and a
//               helper that classifies illegal funct3 values.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR      = 3'd3,
    ST_WR_WAIT = 3'd4
  } lsu_state_t;

  // Loads only define B/H/W/BU/HU; stores only define B/H/W.
  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    if (is_store) begin
      return (f3 > F3_W);
    end
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_mux.sv
`default_nettype none
// ============================================================================
// Module      : lsu_lane_mux
// Description : Combinational byte-lane logic for the load/store unit.
//               Extracts and sign/zero-extends a sub-word from a memory word
//               for loads, and merges store data into a memory word for
//               sub-word stores.
// Ports       : addr_lo   - byte offset within the word
//               func3     - RV32I funct3 of the access
//               word      - word read from memory
//               wdata     - store source register value
//               load_val  - extended load result
//               store_val - word to write back (whole wdata for SW)
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_mux
  import riscv_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  func3,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] store_val
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    load_val = word;
    case (func3)
      F3_B:    load_val = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_val = {24'd0, byte_sel};
      F3_H:    load_val = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_val = {16'd0, half_sel};
      default: load_val = word;
    endcase
  end

  always_comb begin
    store_val = word;
    case (func3)
      F3_B: store_val[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      F3_H: store_val = addr_lo[1] ? {wdata[15:0], word[15:0]}
                                   : {word[31:16], wdata[15:0]};
      default: store_val = wdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : RV32I load/store alignment and sequencing unit sitting between
//               the MEM stage and a word-only data memory. Performs sub-word
//               load extraction, read-modify-write for SB/SH, misalignment and
//               fault detection, and stalls the pipeline until completion.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               req_*               - request from MEM stage (held until resp)
//               req_ready, stall    - handshake / pipeline hold
//               resp_*              - registered one-cycle completion
//               mem_*               - word interface to datamem
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
  import riscv_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_is_store,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_fault,
  output logic        mem_writeEn,
  output logic [31:0] mem_addr,
  output logic [2:0]  mem_func3,
  output logic [31:0] mem_storeVal,
  input  logic [31:0] mem_loadVal,
  input  logic        mem_data_ready
);

  lsu_state_t  state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  func3_q, func3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merged_q, merged_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_mis_q, resp_mis_d;
  logic        resp_fault_q, resp_fault_d;

  logic        accept;
  logic        req_fault;
  logic        req_mis;
  logic        req_half;
  logic        req_word;
  logic [31:0] lane_load;
  logic [31:0] lane_store;

  lsu_lane_mux u_lane_mux (
    .addr_lo   (addr_q[1:0]),
    .func3     (func3_q),
    .word      (mem_loadVal),
    .wdata     (wdata_q),
    .load_val  (lane_load),
    .store_val (lane_store)
  );

  assign req_ready = (state_q == ST_IDLE) && !resp_valid_q;
  assign accept    = req_valid && req_ready;
  assign stall     = req_valid && !resp_valid_q;

  // Fault and misalignment are evaluated independently so both may be reported.
  always_comb begin
    req_half  = (req_func3 == F3_H) || (!req_is_store && (req_func3 == F3_HU));
    req_word  = (req_func3 == F3_W);
    req_fault = f3_illegal(req_is_store, req_func3) || (req_addr >= 32'(MEM_BYTES));
    req_mis   = (req_half && req_addr[0]) || (req_word && (req_addr[1:0] != 2'b00));
  end

  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    func3_d      = func3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    merged_d     = merged_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'd0;
    resp_mis_d   = 1'b0;
    resp_fault_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          is_store_d = req_is_store;
          func3_d    = req_func3;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          merged_d   = req_wdata;
          if (req_fault || req_mis) begin
            // Errored requests never touch memory; respond next cycle.
            resp_valid_d = 1'b1;
            resp_mis_d   = req_mis;
            resp_fault_d = req_fault;
          end else if (req_is_store && (req_func3 == F3_W)) begin
            state_d = ST_WR;
          end else begin
            // Loads and sub-word stores both need the current word first.
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (mem_data_ready) begin
          if (is_store_q) begin
            merged_d = lane_store;
            state_d  = ST_WR;
          end else begin
            resp_rdata_d = lane_load;
            resp_valid_d = 1'b1;
            state_d      = ST_IDLE;
          end
        end
      end
      ST_WR: begin
        state_d = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (mem_data_ready) begin
          resp_valid_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      is_store_q   <= 1'b0;
      func3_q      <= 3'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      merged_q     <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_mis_q   <= 1'b0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      func3_q      <= func3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      merged_q     <= merged_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_mis_q   <= resp_mis_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  assign resp_valid      = resp_valid_q;
  assign resp_rdata      = resp_rdata_q;
  assign resp_misaligned = resp_mis_q;
  assign resp_fault      = resp_fault_q;

  // Memory drive is decoded from registered state. The write strobe is masked
  // by reset so an access aborted in WR cannot land in memory on that edge.
  assign mem_writeEn  = (state_q == ST_WR) && !reset;
  assign mem_addr     = (state_q == ST_IDLE) ? 32'd0 : {addr_q[31:2], 2'b00};
  assign mem_func3    = F3_W;
  assign mem_storeVal = ((state_q == ST_WR) || (state_q == ST_WR_WAIT)) ? merged_q : 32'd0;

endmodule
`default_nettype wire
